// File: rtl/seven_seg_pkg.sv
// Shared constants, scan state type and hex-to-segment table for the
// seven-segment display path.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode display. Each digit
// owns a TICK_DIV-cycle slot that opens with BLANK_CYCLES of all-anodes-off
// to suppress ghosting; the digit value is captured once at slot start.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV     = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0][3:0]      digit,
    input  logic [7:0]           en_dot,
    output logic [7:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int              CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit              HAS_BLANK  = (BLANK_CYCLES > 0);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    scan_state_t      state;

    logic [3:0]       snap_val_p0;
    logic             snap_dot_p0;
    logic [3:0]       cur_val;
    logic             cur_dot;
    logic [6:0]       seg_dec;
    logic [NUM_DIGITS-1:0] an_sel;

    // Slot prescaler and digit index; idx advances on every slot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Blank/drive sequencing within a slot; with no blanking the slot is all drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BLANK;
        end else if (cnt == CNT_LAST) begin
            state <= HAS_BLANK ? BLANK : DRIVE;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            state <= DRIVE;
        end
    end

    // Capture the slot's digit and dot at slot start so mid-slot changes wait a slot.
    always_ff @(posedge clk) begin
        if (cnt == '0) begin
            snap_val_p0 <= digit[idx];
            snap_dot_p0 <= en_dot[idx];
        end
    end

    // At cnt==0 the snapshot is being loaded this edge, so use the live value.
    assign cur_val = (cnt == '0) ? digit[idx]  : snap_val_p0;
    assign cur_dot = (cnt == '0) ? en_dot[idx] : snap_dot_p0;
    assign an_sel  = NUM_DIGITS'(1) << idx;

    hex_to_7seg u_dec (
        .hex (cur_val),
        .seg (seg_dec)
    );

    // Registered pin drivers: one anode low only while driving and enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (en && state == DRIVE) begin
            an  <= ~an_sel;
            seg <= seg_dec;
            dp  <= ~cur_dot;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end
    end

endmodule
